issue_select: RTL and testbench



---
 rtl/issue_select_pkg.sv | 55 +++++
 rtl/issue_select_pick.sv | 27 ++
 rtl/issue_select.sv | 173 +++++++++++++++++
 tb/tb_issue_select.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/issue_select_pkg.sv
// issue_select_pkg: queue geometry, entry field layout and hazard helpers
// shared by the issue-select block and its bench-facing consumers.
package issue_select_pkg;

  localparam int NUM_IQ_ENTRIES      = 8;
  localparam int NUM_IQ_ENTRIES_LOG2 = 3;
  localparam int IQ_ENTRY_SIZE       = 32;
  localparam int IQ_REG_W            = 5;

  // Entry layout: [4:0] rs, [9:5] rt, [14:10] rd, 15 uses_rs,
  // 16 uses_rt, 17 writes_rd, [31:18] opaque payload.
  localparam int IQ_RS_LSB    = 0;
  localparam int IQ_RS_MSB    = 4;
  localparam int IQ_RT_LSB    = 5;
  localparam int IQ_RT_MSB    = 9;
  localparam int IQ_RD_LSB    = 10;
  localparam int IQ_RD_MSB    = 14;
  localparam int IQ_USES_RS   = 15;
  localparam int IQ_USES_RT   = 16;
  localparam int IQ_WRITES_RD = 17;

  typedef struct packed {
    logic [IQ_REG_W-1:0] rs;
    logic [IQ_REG_W-1:0] rt;
    logic [IQ_REG_W-1:0] rd;
    logic                uses_rs;
    logic                uses_rt;
    logic                writes_rd;
  } iq_fields_t;

  function automatic iq_fields_t iq_decode(input logic [IQ_ENTRY_SIZE-1:0] e);
    iq_fields_t f;
    f.rs        = e[IQ_RS_MSB:IQ_RS_LSB];
    f.rt        = e[IQ_RT_MSB:IQ_RT_LSB];
    f.rd        = e[IQ_RD_MSB:IQ_RD_LSB];
    f.uses_rs   = e[IQ_USES_RS];
    f.uses_rt   = e[IQ_USES_RT];
    f.writes_rd = e[IQ_WRITES_RD];
    return f;
  endfunction

  // Older entry writes a register the younger one reads or writes (RAW/WAW).
  function automatic logic writes_into(input iq_fields_t o, input iq_fields_t y);
    return o.writes_rd && ((y.uses_rs && y.rs == o.rd) ||
                           (y.uses_rt && y.rt == o.rd) ||
                           (y.writes_rd && y.rd == o.rd));
  endfunction

  // Older entry still reads the register the younger one would overwrite (WAR).
  function automatic logic reads_rd_of(input iq_fields_t o, input iq_fields_t y);
    return y.writes_rd && ((o.uses_rs && o.rs == y.rd) ||
                           (o.uses_rt && o.rt == y.rd));
  endfunction

endpackage

// File: rtl/issue_select_pick.sv
// iq_pick_oldest: find-first-set over the queue request mask; lowest index
// (oldest entry) wins. Produces one-hot grant, encoded index and found flag.
module iq_pick_oldest
  import issue_select_pkg::*;
(
  input  logic [NUM_IQ_ENTRIES-1:0]      req,
  output logic [NUM_IQ_ENTRIES-1:0]      grant,
  output logic [NUM_IQ_ENTRIES_LOG2-1:0] idx,
  output logic                           found
);

  // Scan from the youngest down so the oldest requester is the last write.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = NUM_IQ_ENTRIES - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
        idx      = NUM_IQ_ENTRIES_LOG2'(i);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/issue_select.sv
// issue_select: picks up to two hazard-free, operand-ready queue entries per
// cycle in age order, pops them from the issue queue and registers them onto
// two execution-port handshakes. A register scoreboard tracks pending writes.
// Build option: ISSUE_DUAL_EN enables the second pick/port; without it port 1
// is tied off while writeback 1 still updates the scoreboard.
module issue_select
  import issue_select_pkg::*;
#(
  parameter int NUM_REGS   = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           flush,
  input  logic [NUM_IQ_ENTRIES_LOG2:0]   count,
  input  logic [IQ_ENTRY_SIZE-1:0]       data0,
  input  logic [IQ_ENTRY_SIZE-1:0]       data1,
  input  logic [IQ_ENTRY_SIZE-1:0]       data2,
  input  logic [IQ_ENTRY_SIZE-1:0]       data3,
  input  logic [IQ_ENTRY_SIZE-1:0]       data4,
  input  logic [IQ_ENTRY_SIZE-1:0]       data5,
  input  logic [IQ_ENTRY_SIZE-1:0]       data6,
  input  logic [IQ_ENTRY_SIZE-1:0]       data7,
  output logic                           pop0,
  output logic [NUM_IQ_ENTRIES_LOG2-1:0] pop_key0,
  output logic                           pop1,
  output logic [NUM_IQ_ENTRIES_LOG2-1:0] pop_key1,
  output logic                           issue0_valid,
  output logic [IQ_ENTRY_SIZE-1:0]       issue0_data,
  input  logic                           issue0_ready,
  output logic                           issue1_valid,
  output logic [IQ_ENTRY_SIZE-1:0]       issue1_data,
  input  logic                           issue1_ready,
  input  logic                           wb0_valid,
  input  logic [REG_ADDR_W-1:0]          wb0_addr,
  input  logic                           wb1_valid,
  input  logic [REG_ADDR_W-1:0]          wb1_addr
);

  localparam int CNT_W = NUM_IQ_ENTRIES_LOG2 + 1;

  logic [IQ_ENTRY_SIZE-1:0]       entry [NUM_IQ_ENTRIES];
  iq_fields_t                     f     [NUM_IQ_ENTRIES];
  logic [NUM_IQ_ENTRIES-1:0]      in_q, elig, grant0;
  logic [NUM_REGS-1:0]            sb, wb_set, sb_byp, sb_next;
  logic [NUM_IQ_ENTRIES_LOG2-1:0] idx0;
  logic                           found0, port0_free, pick_ok;

  assign entry[0] = data0;
  assign entry[1] = data1;
  assign entry[2] = data2;
  assign entry[3] = data3;
  assign entry[4] = data4;
  assign entry[5] = data5;
  assign entry[6] = data6;
  assign entry[7] = data7;

  // Writeback strobes as a register mask; also serves as the source bypass.
  always_comb begin
    wb_set = '0;
    if (wb0_valid) wb_set[wb0_addr] = 1'b1;
    if (wb1_valid) wb_set[wb1_addr] = 1'b1;
  end

  assign sb_byp = sb | wb_set;

  // Per-entry eligibility: operands ready, rd not pending, no hazard vs older valid entries.
  always_comb begin
    for (int i = 0; i < NUM_IQ_ENTRIES; i++) begin
      f[i]    = iq_decode(entry[i]);
      in_q[i] = CNT_W'(i) < count;
    end
    for (int i = 0; i < NUM_IQ_ENTRIES; i++) begin
      elig[i] = in_q[i] &&
                (!f[i].uses_rs   || sb_byp[f[i].rs]) &&
                (!f[i].uses_rt   || sb_byp[f[i].rt]) &&
                (!f[i].writes_rd || sb[f[i].rd]);
      for (int j = 0; j < i; j++) begin
        if (in_q[j] && (writes_into(f[j], f[i]) || reads_rd_of(f[j], f[i])))
          elig[i] = 1'b0;
      end
    end
  end

  iq_pick_oldest u_pick0 (
    .req   (elig),
    .grant (grant0),
    .idx   (idx0),
    .found (found0)
  );

  assign pick_ok    = reset_n && !flush;
  assign port0_free = !issue0_valid || issue0_ready;
  assign pop0       = pick_ok && found0 && port0_free;
  assign pop_key0   = idx0;

`ifdef ISSUE_DUAL_EN
  logic [NUM_IQ_ENTRIES-1:0]      req1, grant1, conf1;
  logic [NUM_IQ_ENTRIES_LOG2-1:0] idx1;
  logic                           found1;

  // Pick-1 candidates: eligible, strictly younger than pick 0, no dependence on pick 0's rd.
  always_comb begin
    for (int i = 0; i < NUM_IQ_ENTRIES; i++)
      conf1[i] = writes_into(f[idx0], f[i]);
    req1 = elig & ~(grant0 | (grant0 - 1'b1)) & ~conf1;
  end

  iq_pick_oldest u_pick1 (
    .req   (req1),
    .grant (grant1),
    .idx   (idx1),
    .found (found1)
  );

  assign pop1     = pop0 && found1 && (!issue1_valid || issue1_ready);
  assign pop_key1 = idx1;

  // Port-1 issue register: load on pick, drop on handshake or flush.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      issue1_valid <= 1'b0;
      issue1_data  <= '0;
    end else if (flush) begin
      issue1_valid <= 1'b0;
    end else if (pop1) begin
      issue1_valid <= 1'b1;
      issue1_data  <= entry[pop_key1];
    end else if (issue1_ready) begin
      issue1_valid <= 1'b0;
    end
  end
`else
  logic unused_dual;

  assign pop1         = 1'b0;
  assign pop_key1     = '0;
  assign issue1_valid = 1'b0;
  assign issue1_data  = '0;
  assign unused_dual  = ^{grant0, issue1_ready};
`endif

  // Port-0 issue register: load on pick, drop on handshake or flush.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      issue0_valid <= 1'b0;
      issue0_data  <= '0;
    end else if (flush) begin
      issue0_valid <= 1'b0;
    end else if (pop0) begin
      issue0_valid <= 1'b1;
      issue0_data  <= entry[pop_key0];
    end else if (issue0_ready) begin
      issue0_valid <= 1'b0;
    end
  end

  // Scoreboard next state: writebacks set, picks clear (clear applied last so it wins).
  always_comb begin
    sb_next = sb | wb_set;
    if (pop0 && f[pop_key0].writes_rd) sb_next[f[pop_key0].rd] = 1'b0;
    if (pop1 && f[pop_key1].writes_rd) sb_next[f[pop_key1].rd] = 1'b0;
    sb_next[0] = 1'b1;
  end

  // Scoreboard register; flush restores every register to ready.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   sb <= '1;
    else if (flush) sb <= '1;
    else            sb <= sb_next;
  end

endmodule

// File: tb/tb_issue_select.sv
// Directed bench for issue_select; expectations adapt to ISSUE_DUAL_EN.
module tb_issue_select;

`ifdef ISSUE_DUAL_EN
  localparam bit DUAL = 1'b1;
`else
  localparam bit DUAL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n, flush;
  logic [3:0]  count;
  logic [31:0] data0, data1, data2, data3, data4, data5, data6, data7;
  logic        pop0, pop1;
  logic [2:0]  pop_key0, pop_key1;
  logic        issue0_valid, issue0_ready, issue1_valid, issue1_ready;
  logic [31:0] issue0_data, issue1_data;
  logic        wb0_valid, wb1_valid;
  logic [4:0]  wb0_addr, wb1_addr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  issue_select dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .count(count),
    .data0(data0), .data1(data1), .data2(data2), .data3(data3),
    .data4(data4), .data5(data5), .data6(data6), .data7(data7),
    .pop0(pop0), .pop_key0(pop_key0), .pop1(pop1), .pop_key1(pop_key1),
    .issue0_valid(issue0_valid), .issue0_data(issue0_data), .issue0_ready(issue0_ready),
    .issue1_valid(issue1_valid), .issue1_data(issue1_data), .issue1_ready(issue1_ready),
    .wb0_valid(wb0_valid), .wb0_addr(wb0_addr), .wb1_valid(wb1_valid), .wb1_addr(wb1_addr)
  );

  // Reg-reg op: rd <- rs, rt; payload tag in the upper bits.
  function automatic logic [31:0] mk(input int tag, input int rd, input int rs, input int rt);
    logic [31:0] e;
    e        = '0;
    e[31:18] = 14'(tag);
    e[14:10] = 5'(rd);
    e[9:5]   = 5'(rt);
    e[4:0]   = 5'(rs);
    e[17:15] = 3'b111;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] e0, e1, e2, e3, e4, e5, e6, e7, e8, e9, e10, e11, e12, e13, e14, e15;

  initial begin
    e0  = mk(1, 3, 1, 2);    e1  = mk(2, 4, 5, 6);
    e2  = mk(3, 9, 3, 1);    e3  = mk(4, 10, 1, 2);
    e4  = mk(5, 11, 10, 1);  e5  = mk(6, 12, 9, 1);
    e6  = mk(7, 13, 1, 2);   e7  = mk(8, 1, 2, 2);
    e8  = mk(9, 14, 1, 2);   e9  = mk(10, 15, 1, 2);
    e10 = mk(11, 20, 1, 2);  e11 = mk(12, 21, 20, 1);
    e12 = mk(13, 3, 1, 2);   e13 = mk(14, 16, 3, 20);
    e14 = mk(15, 17, 1, 2);  e15 = mk(16, 17, 16, 15);

    reset_n = 1'b0; flush = 1'b0; count = 4'd2;
    data0 = e0; data1 = e1; data2 = '0; data3 = '0;
    data4 = '0; data5 = '0; data6 = '0; data7 = '0;
    issue0_ready = 1'b1; issue1_ready = 1'b1;
    wb0_valid = 1'b0; wb0_addr = '0; wb1_valid = 1'b0; wb1_addr = '0;
    #1;
    chk("rst_pop0", 32'(pop0), 0);
    chk("rst_v0", 32'(issue0_valid), 0);
    chk("rst_d0", issue0_data, 0);
    chk("rst_v1", 32'(issue1_valid), 0);

    // Two independent entries
    @(negedge clk); reset_n = 1'b1; #1;
    chk("ind_pop0", 32'(pop0), 1);
    chk("ind_key0", 32'(pop_key0), 0);
    chk("ind_pop1", 32'(pop1), 32'(DUAL));
    chk("ind_key1", 32'(pop_key1), DUAL ? 1 : 0);
    tick();
    chk("ind_v0", 32'(issue0_valid), 1);
    chk("ind_d0", issue0_data, e0);
    chk("ind_v1", 32'(issue1_valid), 32'(DUAL));
    chk("ind_d1", issue1_data, DUAL ? e1 : 32'h0);
    @(negedge clk); count = DUAL ? 4'd0 : 4'd1; data0 = e1; data1 = '0; #1;
    chk("ind2_pop0", 32'(pop0), 32'(!DUAL));
    chk("ind2_key0", 32'(pop_key0), 0);
    chk("ind2_pop1", 32'(pop1), 0);
    tick();
    chk("ind2_v0", 32'(issue0_valid), 32'(!DUAL));
    chk("ind2_d0", issue0_data, DUAL ? e0 : e1);
    chk("ind2_v1", 32'(issue1_valid), 0);

    // Empty queue ignores data; wb1 restores r4
    @(negedge clk); count = 4'd0; data0 = e3; wb1_valid = 1'b1; wb1_addr = 5'd4; #1;
    chk("cnt0_pop0", 32'(pop0), 0);
    tick();
    chk("idle_v0", 32'(issue0_valid), 0);

    // Source r3 pending, then writeback bypass
    @(negedge clk); wb1_valid = 1'b0; count = 4'd1; data0 = e2; #1;
    chk("dep_pop0", 32'(pop0), 0);
    @(negedge clk); wb0_valid = 1'b1; wb0_addr = 5'd3; #1;
    chk("byp_pop0", 32'(pop0), 1);
    chk("byp_key0", 32'(pop_key0), 0);
    tick();
    chk("byp_v0", 32'(issue0_valid), 1);
    chk("byp_d0", issue0_data, e2);

    // RAW inside the queue
    @(negedge clk); wb0_valid = 1'b0; count = 4'd2; data0 = e3; data1 = e4; #1;
    chk("raw_pop0", 32'(pop0), 1);
    chk("raw_key0", 32'(pop_key0), 0);
    chk("raw_pop1", 32'(pop1), 0);
    tick();
    chk("raw_d0", issue0_data, e3);
    @(negedge clk); count = 4'd1; data0 = e4; data1 = '0; #1;
    chk("raw2_pop0", 32'(pop0), 0);
    tick();
    chk("raw2_v0", 32'(issue0_valid), 0);
    @(negedge clk); wb0_valid = 1'b1; wb0_addr = 5'd10; #1;
    chk("raw3_pop0", 32'(pop0), 1);
    tick();
    chk("raw3_d0", issue0_data, e4);

    // Oldest entry blocked on r9; younger independent entry picked
    @(negedge clk); wb0_valid = 1'b0; count = 4'd2; data0 = e5; data1 = e6; #1;
    chk("skip_pop0", 32'(pop0), 1);
    chk("skip_key0", 32'(pop_key0), 1);
    chk("skip_pop1", 32'(pop1), 0);
    tick();
    chk("skip_d0", issue0_data, e6);

    // WAR: younger writes r1 that the blocked older entry reads
    @(negedge clk); data1 = e7; #1;
    chk("war_pop0", 32'(pop0), 0);
    tick();
    chk("war_v0", 32'(issue0_valid), 0);

    // Stall: data holds, no pick until ready, then back-to-back pick
    @(negedge clk); count = 4'd1; data0 = e8; data1 = '0; #1;
    chk("st_pop0", 32'(pop0), 1);
    tick();
    chk("st_v0", 32'(issue0_valid), 1);
    @(negedge clk); issue0_ready = 1'b0; data0 = e9;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("st_nopop", 32'(pop0), 0);
      tick();
      chk("st_hold", issue0_data, e8);
      @(negedge clk);
    end
    issue0_ready = 1'b1; #1;
    chk("st_rel_pop0", 32'(pop0), 1);
    chk("st_rel_key0", 32'(pop_key0), 0);
    tick();
    chk("st_rel_d0", issue0_data, e9);

    // Clear wins over same-cycle writeback to r20
    @(negedge clk); data0 = e10; wb0_valid = 1'b1; wb0_addr = 5'd20; #1;
    chk("cw_pop0", 32'(pop0), 1);
    tick();
    @(negedge clk); wb0_valid = 1'b0; data0 = e11; #1;
    chk("cw_dep_pop0", 32'(pop0), 0);
    tick();

    // Flush during a stall with r3 pending
    @(negedge clk); data0 = e12; #1;
    chk("fl_pop0", 32'(pop0), 1);
    tick();
    chk("fl_v0", 32'(issue0_valid), 1);
    @(negedge clk); issue0_ready = 1'b0; data0 = e13; #1;
    chk("fl_dep_pop0", 32'(pop0), 0);
    tick();
    @(negedge clk); flush = 1'b1; data0 = e14; #1;
    chk("fl1_pop0", 32'(pop0), 0);
    tick();
    chk("fl1_v0", 32'(issue0_valid), 0);
    @(negedge clk); #1;
    chk("fl2_pop0", 32'(pop0), 0);
    tick();
    @(negedge clk); flush = 1'b0; issue0_ready = 1'b1; data0 = e13; #1;
    chk("pfl_pop0", 32'(pop0), 1);
    tick();
    chk("pfl_v0", 32'(issue0_valid), 1);
    chk("pfl_d0", issue0_data, e13);

    // Asynchronous reset mid-run
    #2; reset_n = 1'b0; #1;
    chk("rm_v0", 32'(issue0_valid), 0);
    chk("rm_d0", issue0_data, 0);
    chk("rm_pop0", 32'(pop0), 0);
    @(negedge clk); reset_n = 1'b1; data0 = e15; #1;
    chk("rr_pop0", 32'(pop0), 1);
    tick();
    chk("rr_d0", issue0_data, e15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
